vga_sync_monitor: RTL and testbench



---
 rtl/vga_timing_pkg.sv | 33 +++
 rtl/sync_edge_det.sv | 26 ++
 rtl/vga_sync_monitor.sv | 166 ++++++++++++++++
 tb/tb_vga_sync_monitor.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_timing_pkg.sv
// Shared 640x480@60 timing defaults, monitor FSM encoding and debug error codes.
package vga_timing_pkg;

  localparam int unsigned H_ACTIVE_DEF    = 640;
  localparam int unsigned H_TOTAL_DEF     = 800;
  localparam int unsigned H_SYNC_DEF      = 96;
  localparam int unsigned H_BP_DEF        = 48;
  localparam int unsigned V_ACTIVE_DEF    = 480;
  localparam int unsigned V_TOTAL_DEF     = 525;
  localparam int unsigned V_SYNC_DEF      = 2;
  localparam int unsigned V_BP_DEF        = 33;
  localparam int unsigned LOCK_FRAMES_DEF = 2;

  typedef enum logic [1:0] {
    StSearch = 2'd0,
    StTrack  = 2'd1,
    StLocked = 2'd2
  } mon_state_e;

  // E1..E4, used as bit positions of the per-pixel error vector.
  typedef enum logic [1:0] {
    ErrLinePeriod  = 2'd0,
    ErrSyncWidth   = 2'd1,
    ErrFramePeriod = 2'd2,
    ErrTimeout     = 2'd3
  } err_code_e;

  function automatic logic [10:0] wrap_count(input logic [10:0] raw, input int unsigned offset,
                                             input int unsigned total);
    return 11'((32'(raw) + offset) % total);
  endfunction

endpackage

// File: rtl/sync_edge_det.sv
// Pixel-rate sync sampler with leading/trailing edge pulses relative to SYNC_POL.
module sync_edge_det #(
  parameter bit SYNC_POL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic pix_en,
  input  logic sync_line,
  output logic lead,
  output logic trail
);

  logic samp_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      samp_q <= ~SYNC_POL;
    end else if (pix_en) begin
      samp_q <= sync_line;
    end
  end

  assign lead  = pix_en && (sync_line != samp_q) && (sync_line == SYNC_POL);
  assign trail = pix_en && (sync_line != samp_q) && (sync_line != SYNC_POL);

endmodule

// File: rtl/vga_sync_monitor.sv
// VGA sync receiver: rebuilds coordinates from HS/VS edges and checks timing.
// Define VGA_MON_ERR_CNT_EN to build the saturating err_count counter.
module vga_sync_monitor
  import vga_timing_pkg::*;
#(
  parameter int unsigned H_ACTIVE    = H_ACTIVE_DEF,
  parameter int unsigned H_TOTAL     = H_TOTAL_DEF,
  parameter int unsigned H_SYNC      = H_SYNC_DEF,
  parameter int unsigned H_BP        = H_BP_DEF,
  parameter int unsigned V_ACTIVE    = V_ACTIVE_DEF,
  parameter int unsigned V_TOTAL     = V_TOTAL_DEF,
  parameter int unsigned V_SYNC      = V_SYNC_DEF,
  parameter int unsigned V_BP        = V_BP_DEF,
  parameter bit          SYNC_POL    = 1'b0,
  parameter int unsigned LOCK_FRAMES = LOCK_FRAMES_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pix_en,
  input  logic        HS,
  input  logic        VS,
  output logic [10:0] hcount,
  output logic [10:0] vcount,
  output logic        active,
  output logic        frame_start,
  output logic        locked,
  output logic        err,
  output logic [15:0] err_count
);

  localparam logic [10:0] RawMax     = 11'h7FF;
  localparam logic [10:0] HLast      = 11'(H_TOTAL - 1);
  localparam logic [10:0] HSyncLast  = 11'(H_SYNC - 1);
  localparam logic [10:0] TimeoutPre = 11'(2 * H_TOTAL - 2);
  localparam int unsigned HOffset    = H_TOTAL - H_SYNC - H_BP;
  localparam int unsigned VOffset    = V_TOTAL - V_SYNC - V_BP;

  mon_state_e  state_q;
  logic [7:0]  good_q;
  logic [10:0] hraw_q, vraw_q, hraw_d, vraw_d;
  logic [10:0] hcount_q, vcount_q, hcount_d, vcount_d;
  logic        h_ref_q, v_ref_q;
  logic        active_q, frame_start_q, locked_q, err_q;
  logic        hs_lead, hs_trail, vs_lead, vs_trail_unused;
  logic [11:0] lines;
  logic [3:0]  err_vec;
  logic        any_err, enter_locked, locked_d;

  sync_edge_det #(.SYNC_POL(SYNC_POL)) u_hs_edge (
    .clk      (clk),
    .rst      (rst),
    .pix_en   (pix_en),
    .sync_line(HS),
    .lead     (hs_lead),
    .trail    (hs_trail)
  );

  sync_edge_det #(.SYNC_POL(SYNC_POL)) u_vs_edge (
    .clk      (clk),
    .rst      (rst),
    .pix_en   (pix_en),
    .sync_line(VS),
    .lead     (vs_lead),
    .trail    (vs_trail_unused)
  );

  always_comb begin
    hraw_d = hraw_q;
    if (hs_lead) hraw_d = '0;
    else if (hraw_q != RawMax) hraw_d = hraw_q + 11'd1;

    vraw_d = vraw_q;
    if (vs_lead) vraw_d = '0;
    else if (hs_lead && (vraw_q != RawMax)) vraw_d = vraw_q + 11'd1;

    // An HS edge coinciding with the VS edge still closes the previous frame's last line.
    lines = {1'b0, vraw_q} + {11'd0, hs_lead};

    err_vec                 = '0;
    err_vec[ErrLinePeriod]  = hs_lead && h_ref_q && (hraw_q != HLast);
    err_vec[ErrSyncWidth]   = hs_trail && (hraw_q != HSyncLast);
    err_vec[ErrFramePeriod] = vs_lead && v_ref_q && (32'(lines) != V_TOTAL);
    err_vec[ErrTimeout]     = pix_en && !hs_lead && !hs_trail && (hraw_q == TimeoutPre);
    any_err                 = |err_vec;

    enter_locked = (state_q == StTrack) && vs_lead && ((32'(good_q) + 32'd1) >= LOCK_FRAMES);
    locked_d     = !any_err && ((state_q == StLocked) || enter_locked);

    hcount_d = wrap_count(hraw_d, HOffset, H_TOTAL);
    vcount_d = wrap_count(vraw_d, VOffset, V_TOTAL);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= StSearch;
      good_q        <= '0;
      hraw_q        <= '0;
      vraw_q        <= '0;
      h_ref_q       <= 1'b0;
      v_ref_q       <= 1'b0;
      hcount_q      <= '0;
      vcount_q      <= '0;
      active_q      <= 1'b0;
      frame_start_q <= 1'b0;
      locked_q      <= 1'b0;
      err_q         <= 1'b0;
    end else begin
      err_q         <= 1'b0;
      frame_start_q <= 1'b0;
      if (pix_en) begin
        hraw_q        <= hraw_d;
        vraw_q        <= vraw_d;
        // Any error drops the timing reference, so the next edge only re-anchors.
        h_ref_q       <= !any_err && (h_ref_q || hs_lead);
        v_ref_q       <= !any_err && (v_ref_q || vs_lead);
        hcount_q      <= hcount_d;
        vcount_q      <= vcount_d;
        err_q         <= any_err;
        frame_start_q <= (hcount_d == 11'd0) && (vcount_d == 11'd0);
        locked_q      <= locked_d;
        active_q      <= locked_d && (32'(hcount_d) < H_ACTIVE) && (32'(vcount_d) < V_ACTIVE);
        unique case (state_q)
          StSearch: begin
            if (!any_err && vs_lead) begin
              state_q <= StTrack;
              good_q  <= '0;
            end
          end
          StTrack: begin
            if (any_err) state_q <= StSearch;
            else if (enter_locked) state_q <= StLocked;
            else if (vs_lead) good_q <= good_q + 8'd1;
          end
          StLocked: begin
            if (any_err) state_q <= StSearch;
          end
          default: state_q <= StSearch;
        endcase
      end
    end
  end

  assign hcount      = hcount_q;
  assign vcount      = vcount_q;
  assign active      = active_q;
  assign frame_start = frame_start_q;
  assign locked      = locked_q;
  assign err         = err_q;

`ifdef VGA_MON_ERR_CNT_EN
  logic [15:0] err_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      err_cnt_q <= '0;
    end else if (any_err && (err_cnt_q != 16'hFFFF)) begin
      err_cnt_q <= err_cnt_q + 16'd1;
    end
  end

  assign err_count = err_cnt_q;
`else
  assign err_count = '0;
`endif

endmodule

// File: tb/tb_vga_sync_monitor.sv
// Scoreboard bench for vga_sync_monitor using a reduced 32x10 timing to keep frames short.
module tb_vga_sync_monitor;

  localparam int unsigned HA = 20, HT = 32, HSY = 4, HBP = 4;
  localparam int unsigned VA = 6, VT = 10, VSY = 2, VBP = 1, LF = 2;
  localparam int unsigned TO = 2 * HT - 1;

  logic        clk = 1'b0;
  logic        rst, pix_en, HS, VS;
  logic [10:0] hcount, vcount;
  logic        active, frame_start, locked, err;
  logic [15:0] err_count;

  vga_sync_monitor #(
    .H_ACTIVE(HA), .H_TOTAL(HT), .H_SYNC(HSY), .H_BP(HBP),
    .V_ACTIVE(VA), .V_TOTAL(VT), .V_SYNC(VSY), .V_BP(VBP),
    .SYNC_POL(1'b0), .LOCK_FRAMES(LF)
  ) dut (
    .clk(clk), .rst(rst), .pix_en(pix_en), .HS(HS), .VS(VS),
    .hcount(hcount), .vcount(vcount), .active(active), .frame_start(frame_start),
    .locked(locked), .err(err), .err_count(err_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [10:0] hc;
    logic [10:0] vc;
    logic        act;
    logic        fs;
    logic        lk;
    logic        er;
    logic [15:0] ec;
  } exp_t;

  exp_t sb[$];
  int checks = 0, errors = 0;
  int obs_err, obs_fs;

  // Reference model state
  bit m_hs, m_vs, m_href, m_vref;
  int m_hraw, m_vraw, m_lines, m_state, m_good, m_errs;

  // Sync generator position and one-shot line/frame overrides
  int gh = 0, gv = 0, cur_len = HT, cur_hsw = HSY, cur_lines = VT;

  task automatic model_reset();
    m_hs = 1'b1; m_vs = 1'b1; m_href = 1'b0; m_vref = 1'b0;
    m_hraw = 0; m_vraw = 0; m_lines = 0; m_state = 0; m_good = 0; m_errs = 0;
  endtask

  task automatic model_step(input bit hs, input bit vs, output exp_t e);
    bit hl, ht, vl, bad;
    int hc, vc;
    hl = (hs != m_hs) && !hs;
    ht = (hs != m_hs) && hs;
    vl = (vs != m_vs) && !vs;
    if (hl) m_lines++;
    bad = 1'b0;
    if (hl && m_href && (m_hraw != HT - 1)) bad = 1'b1;
    if (ht && (m_hraw != HSY - 1)) bad = 1'b1;
    if (vl && m_vref && (m_lines != VT)) bad = 1'b1;
    if (!hl && !ht && (m_hraw == TO - 1)) bad = 1'b1;
    m_hraw = hl ? 0 : ((m_hraw < 2047) ? m_hraw + 1 : 2047);
    if (vl) begin
      m_vraw = 0;
      m_lines = 0;
    end else if (hl && (m_vraw < 2047)) begin
      m_vraw++;
    end
    if (bad) m_state = 0;
    else if (m_state == 0 && vl) begin
      m_state = 1;
      m_good = 0;
    end else if (m_state == 1 && vl) begin
      m_good++;
      if (m_good >= LF) m_state = 2;
    end
    m_href = !bad && (m_href || hl);
    m_vref = !bad && (m_vref || vl);
    m_hs = hs;
    m_vs = vs;
    if (bad && m_errs < 65535) m_errs++;
    hc = (m_hraw + HT - HSY - HBP) % HT;
    vc = (m_vraw + VT - VSY - VBP) % VT;
    e.hc  = 11'(hc);
    e.vc  = 11'(vc);
    e.lk  = (m_state == 2);
    e.act = e.lk && (hc < HA) && (vc < VA);
    e.fs  = (hc == 0) && (vc == 0);
    e.er  = bad;
`ifdef VGA_MON_ERR_CNT_EN
    e.ec  = 16'(m_errs);
`else
    e.ec  = 16'd0;
`endif
  endtask

  // One pixel period = 4 clk: pix_en strobe, result check, pulse/hold check, idle.
  task automatic tick(input bit hs, input bit vs);
    exp_t e;
    @(negedge clk);
    pix_en = 1'b1; HS = hs; VS = vs;
    model_step(hs, vs, e);
    sb.push_back(e);
    @(negedge clk);
    pix_en = 1'b0;
    e = sb.pop_front();
    checks++;
    if ({hcount, vcount, active, frame_start, locked, err, err_count} !== e) begin
      errors++;
      $display("FAIL scoreboard t=%0t got hc=%0d vc=%0d act=%b fs=%b lk=%b err=%b ec=%0d want hc=%0d vc=%0d act=%b fs=%b lk=%b err=%b ec=%0d",
               $time, hcount, vcount, active, frame_start, locked, err, err_count,
               e.hc, e.vc, e.act, e.fs, e.lk, e.er, e.ec);
    end
    if (err === 1'b1) obs_err++;
    if (frame_start === 1'b1) obs_fs++;
    @(negedge clk);
    checks++;
    if ({err, frame_start, hcount, vcount, locked} !== {2'b00, e.hc, e.vc, e.lk}) begin
      errors++;
      $display("FAIL pulse_hold t=%0t got err=%b fs=%b hc=%0d vc=%0d lk=%b want err=0 fs=0 hc=%0d vc=%0d lk=%b",
               $time, err, frame_start, hcount, vcount, locked, e.hc, e.vc, e.lk);
    end
    @(negedge clk);
  endtask

  task automatic gen_pixel();
    tick(!(gh < cur_hsw), !(gv < VSY));
    gh++;
    if (gh >= cur_len) begin
      gh = 0; cur_len = HT; cur_hsw = HSY; gv++;
      if (gv >= cur_lines) begin
        gv = 0; cur_lines = VT;
      end
    end
  endtask

  task automatic run_lines(input int n);
    repeat (n) begin
      do gen_pixel(); while (gh != 0);
    end
  endtask

  task automatic run_to_frame_end();
    do gen_pixel(); while (!(gh == 0 && gv == 0));
  endtask

  task automatic run_frames(input int n);
    repeat (n) run_to_frame_end();
  endtask

  task automatic check_bit(input string name, input logic got, input logic want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got=%b want=%b", name, got, want);
    end
  endtask

  task automatic check_int(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s got=%0d want=%0d", name, got, want);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; pix_en = 1'b0; HS = 1'b1; VS = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    model_reset();
    checks++;
    if ({hcount, vcount, active, frame_start, locked, err, err_count} !== '0) begin
      errors++;
      $display("FAIL reset_values got hc=%0d vc=%0d act=%b fs=%b lk=%b err=%b ec=%0d want all 0",
               hcount, vcount, active, frame_start, locked, err, err_count);
    end
  endtask

  task automatic test_nominal();
    obs_err = 0; obs_fs = 0;
    run_frames(3);
    check_bit("nominal_locked", locked, 1'b1);
    check_int("nominal_err_pulses", obs_err, 0);
    check_int("nominal_frame_starts", obs_fs, 3);
  endtask

  task automatic test_long_line();
    obs_err = 0;
    cur_len = HT + 1;
    run_lines(2);
    check_int("long_line_err_pulses", obs_err, 1);
    check_bit("long_line_unlocked", locked, 1'b0);
    run_to_frame_end();
    run_frames(3);
    check_bit("long_line_relocked", locked, 1'b1);
    check_int("long_line_err_total", obs_err, 1);
  endtask

  task automatic test_short_hsync();
    obs_err = 0;
    cur_hsw = HSY - 1;
    run_lines(1);
    check_int("short_hsync_err_pulses", obs_err, 1);
    check_bit("short_hsync_unlocked", locked, 1'b0);
    run_to_frame_end();
    run_frames(3);
    check_bit("short_hsync_relocked", locked, 1'b1);
  endtask

  task automatic test_short_frame();
    obs_err = 0;
    cur_lines = VT - 1;
    run_frames(1);
    check_int("short_frame_no_err_yet", obs_err, 0);
    run_lines(1);
    check_int("short_frame_err_pulses", obs_err, 1);
    check_bit("short_frame_unlocked", locked, 1'b0);
    run_to_frame_end();
    run_frames(3);
    check_bit("short_frame_relocked", locked, 1'b1);
  endtask

  task automatic test_timeout();
    obs_err = 0;
    repeat (2100) tick(1'b1, 1'b1);
    check_int("timeout_err_once", obs_err, 1);
    // hraw pinned at 2047 maps to (2047 + 24) mod 32
    check_int("timeout_hraw_saturated", int'(hcount), 23);
    check_bit("timeout_unlocked", locked, 1'b0);
    run_frames(4);
    check_bit("timeout_relocked", locked, 1'b1);
    check_int("timeout_no_more_err", obs_err, 1);
  endtask

  task automatic test_reset_midline();
    run_lines(4);
    repeat (14) gen_pixel();
    check_bit("midline_locked_before_rst", locked, 1'b1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    checks++;
    if ({hcount, vcount, active, frame_start, locked, err, err_count} !== '0) begin
      errors++;
      $display("FAIL midline_reset got hc=%0d vc=%0d act=%b fs=%b lk=%b err=%b ec=%0d want all 0",
               hcount, vcount, active, frame_start, locked, err, err_count);
    end
    obs_err = 0;
    run_to_frame_end();
    run_frames(3);
    check_bit("midline_relocked", locked, 1'b1);
    check_int("midline_err_pulses", obs_err, 0);
  endtask

`ifdef VGA_MON_ERR_CNT_EN
  task automatic test_err_count_sat();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0; HS = 1'b1; VS = 1'b1;
    // Each 1-tick hsync pulse ends with a width error: 65540 errors in total.
    for (int i = 0; i < 131080; i++) begin
      @(negedge clk);
      pix_en = 1'b1;
      HS = (i % 2 == 1);
    end
    @(negedge clk);
    pix_en = 1'b0;
    check_int("err_count_saturated", int'(err_count), 16'hFFFF);
  endtask
`endif

  initial begin
    test_reset();
    test_nominal();
    test_long_line();
    test_short_hsync();
    test_short_frame();
    test_timeout();
    test_reset_midline();
`ifdef VGA_MON_ERR_CNT_EN
    test_err_count_sat();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL watchdog simulation did not complete in time");
    $fatal(1);
  end

endmodule
